// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed display scan controller.
package disp_scan_ctrl_pkg;

    localparam logic AN_OFF  = 1'b1;
    localparam logic SEG_OFF = 1'b1;

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_tick_gen.sv
// Slot counter and digit index; flags slot/frame ends and the blanking guard window.
module scan_tick_gen
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 500,
    localparam int unsigned IW      = idx_width(N_DIGITS),
    localparam int unsigned CW      = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] digit_idx,
    output logic          slot_end,
    output logic          frame_end,
    output logic          in_guard
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            cnt       <= '0;
            digit_idx <= (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign slot_end  = (cnt == CW'(PRESCALE - 1));
    assign frame_end = slot_end && (digit_idx == IW'(N_DIGITS - 1));
    assign in_guard  = (cnt < CW'(GUARD));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scanner with guard blanking, leading-zero blanking and
// frame-synchronous value updates through a load/ack handshake.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 500,
    localparam int unsigned IW      = idx_width(N_DIGITS),
    localparam int unsigned VW      = 4 * N_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [VW-1:0]       value_in,
    input  logic [N_DIGITS-1:0] dp_in,
    input  logic                blank_lz,
    output logic [3:0]          bcd_out,
    output logic [N_DIGITS-1:0] an,
    output logic                dp_out,
    output logic [IW-1:0]       digit_idx,
    output logic                frame_done,
    output logic                load_ack
);

    logic                slot_end;
    logic                frame_end;
    logic                in_guard;
    logic                boundary;
    logic [0:0]          state;
    logic [VW-1:0]       disp;
    logic [N_DIGITS-1:0] disp_dp;
    logic [VW-1:0]       shadow;
    logic [N_DIGITS-1:0] shadow_dp;
    logic                pending;
    logic [N_DIGITS-1:0] blank;
    logic                zero_above;

    scan_tick_gen #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE),
        .GUARD    (GUARD)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_idx (digit_idx),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .in_guard  (in_guard)
    );

    assign boundary   = slot_end && frame_end;
    assign state      = in_guard ? ST_GUARD : ST_ON;
    assign frame_done = boundary;
    assign load_ack   = boundary && pending;

    // A load coinciding with the boundary re-arms pending for the following frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp      <= '0;
            disp_dp   <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            pending   <= 1'b0;
        end else begin
            if (boundary && pending) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
                pending <= 1'b0;
            end
            if (load) begin
                shadow    <= value_in;
                shadow_dp <= dp_in;
                pending   <= 1'b1;
            end
        end
    end

    // Leading-zero mask, scanned from the most significant digit down.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp[4*k +: 4] == 4'd0);
            if (k != 0) begin
                blank[k] = blank_lz && zero_above;
            end
        end
    end

    always_comb begin
        bcd_out = disp[{digit_idx, 2'b00} +: 4];
        an      = {N_DIGITS{AN_OFF}};
        dp_out  = SEG_OFF;
        if (state == ST_ON && !blank[digit_idx]) begin
            an[digit_idx] = ~AN_OFF;
            dp_out        = ~disp_dp[digit_idx];
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with N_DIGITS=4, PRESCALE=8, GUARD=2.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        load_ack;

    int checks;
    int failures;
    int ack_cnt;
    int m_cnt;
    int m_idx;

    disp_scan_ctrl #(
        .N_DIGITS (4),
        .PRESCALE (8),
        .GUARD    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .bcd_out    (bcd_out),
        .an         (an),
        .dp_out     (dp_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the slot model follows the reset level seen at the edge.
    task automatic tick();
        logic r;
        r = rst_n;
        @(posedge clk);
        #1;
        if (!r) begin
            m_cnt = 0;
            m_idx = 0;
        end else if (m_cnt == 7) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_cycle(input logic [15:0] val, input logic [3:0] dpm, input logic [3:0] blk);
        logic       off;
        logic [3:0] e_an;
        logic       e_dp;
        logic       e_fd;
        logic [3:0] e_bcd;
        off   = (m_cnt < 2) || blk[m_idx];
        e_an  = off ? 4'hF : ~(4'b0001 << m_idx);
        e_dp  = off ? 1'b1 : ~dpm[m_idx];
        e_fd  = (m_cnt == 7) && (m_idx == 3);
        e_bcd = val[m_idx*4 +: 4];
        chk("an", 16'(an), 16'(e_an));
        chk("dp_out", 16'(dp_out), 16'(e_dp));
        chk("bcd_out", 16'(bcd_out), 16'(e_bcd));
        chk("digit_idx", 16'(digit_idx), 16'(m_idx));
        chk("frame_done", 16'(frame_done), 16'(e_fd));
        chk("ack_outside_frame_end", 16'(load_ack & ~e_fd), 16'd0);
        if (load_ack === 1'b1) ack_cnt++;
    endtask

    task automatic run_cycles(input int n, input logic [15:0] val, input logic [3:0] dpm,
                              input logic [3:0] blk);
        for (int i = 0; i < n; i++) begin
            check_cycle(val, dpm, blk);
            tick();
        end
    endtask

    task automatic run_to_frame_end(input logic [15:0] val, input logic [3:0] dpm,
                                    input logic [3:0] blk, input logic exp_ack);
        while (!(m_cnt == 7 && m_idx == 3)) begin
            check_cycle(val, dpm, blk);
            tick();
        end
        check_cycle(val, dpm, blk);
        chk("ack_at_frame_end", 16'(load_ack), 16'(exp_ack));
        tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [15:0] cur, input logic [3:0] cur_dp, input logic [3:0] blk);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        check_cycle(cur, cur_dp, blk);
        tick();
        load = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ack_cnt  = 0;
        m_cnt    = 0;
        m_idx    = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;

        // 1. reset and first slot
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cycle(16'h0000, 4'h0, 4'h0);
        end
        rst_n = 1'b1;
        run_cycles(8, 16'h0000, 4'h0, 4'h0);
        chk("idx_after_slot0", 16'(digit_idx), 16'd1);

        // 2. load during digit 1, applied at the frame boundary
        ack_cnt = 0;
        do_load(16'h1234, 4'h0, 16'h0000, 4'h0, 4'h0);
        run_to_frame_end(16'h0000, 4'h0, 4'h0, 1'b1);
        run_cycles(32, 16'h1234, 4'h0, 4'h0);
        chk("acks_load_1234", 16'(ack_cnt), 16'd1);

        // 3. two loads in one frame, single ack
        ack_cnt = 0;
        run_cycles(3, 16'h1234, 4'h0, 4'h0);
        do_load(16'hAAAA, 4'h0, 16'h1234, 4'h0, 4'h0);
        run_cycles(10, 16'h1234, 4'h0, 4'h0);
        do_load(16'h0987, 4'h0, 16'h1234, 4'h0, 4'h0);
        run_to_frame_end(16'h1234, 4'h0, 4'h0, 1'b1);
        run_cycles(32, 16'h0987, 4'h0, 4'h0);
        chk("acks_double_load", 16'(ack_cnt), 16'd1);

        // 4. leading-zero blanking
        do_load(16'h0050, 4'h0, 16'h0987, 4'h0, 4'h0);
        run_to_frame_end(16'h0987, 4'h0, 4'h0, 1'b1);
        blank_lz = 1'b1;
        run_cycles(32, 16'h0050, 4'h0, 4'b1100);
        do_load(16'h0000, 4'h0, 16'h0050, 4'h0, 4'b1100);
        run_to_frame_end(16'h0050, 4'h0, 4'b1100, 1'b1);
        run_cycles(32, 16'h0000, 4'h0, 4'b1110);
        blank_lz = 1'b0;

        // 5. decimal point on digit 2 only
        do_load(16'h5678, 4'b0100, 16'h0000, 4'h0, 4'h0);
        run_to_frame_end(16'h0000, 4'h0, 4'h0, 1'b1);
        run_cycles(32, 16'h5678, 4'b0100, 4'h0);

        // 6. reset mid-ON of digit 2 with a load pending
        ack_cnt = 0;
        do_load(16'h4321, 4'b0001, 16'h5678, 4'b0100, 4'h0);
        run_cycles(18, 16'h5678, 4'b0100, 4'h0);
        check_cycle(16'h5678, 4'b0100, 4'h0);
        rst_n = 1'b0;
        tick();
        check_cycle(16'h0000, 4'h0, 4'h0);
        rst_n = 1'b1;
        run_cycles(40, 16'h0000, 4'h0, 4'h0);
        chk("acks_after_reset", 16'(ack_cnt), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
